// File: rtl/commit_scheduler_if.sv
// Decoder / writeback / commit / operand-lookup bundle for the commit scheduler.
// The scheduler connects through the slave modport, its surroundings through master.
interface commit_scheduler_if #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
);
  logic                 alloc_valid;
  logic [REG_WIDTH-1:0] alloc_reg_id;
  logic                 alloc_ready;
  logic [ROB_WIDTH-1:0] alloc_rob_id;

  logic                 wb_valid;
  logic [ROB_WIDTH-1:0] wb_rob_id;
  logic [31:0]          wb_data;
  logic                 wb_mispredict;

  logic [REG_WIDTH-1:0] commit_reg_id;
  logic [31:0]          commit_data;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic                 flush;

  logic [ROB_WIDTH-1:0] rob_rob_id_j, rob_rob_id_k;
  logic                 rob_ready_j, rob_ready_k;
  logic [31:0]          rob_data_j, rob_data_k;

  modport master (
    output alloc_valid, alloc_reg_id, wb_valid, wb_rob_id, wb_data, wb_mispredict,
           rob_rob_id_j, rob_rob_id_k,
    input  alloc_ready, alloc_rob_id, commit_reg_id, commit_data, commit_rob_id, flush,
           rob_ready_j, rob_ready_k, rob_data_j, rob_data_k
  );

  modport slave (
    input  alloc_valid, alloc_reg_id, wb_valid, wb_rob_id, wb_data, wb_mispredict,
           rob_rob_id_j, rob_rob_id_k,
    output alloc_ready, alloc_rob_id, commit_reg_id, commit_data, commit_rob_id, flush,
           rob_ready_j, rob_ready_k, rob_data_j, rob_data_k
  );
endinterface

// File: rtl/commit_scheduler.sv
// In-order reorder buffer: allocates ids, records writebacks, retires one ready head
// per cycle onto the register-file commit port and flushes after a mispredicted branch.
module commit_scheduler #(
  parameter int ROB_WIDTH = 3,
  parameter int REG_WIDTH = 5
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  commit_scheduler_if.slave bus
);
  localparam int                  SIZE   = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0]  SIZE_C = (ROB_WIDTH+1)'(SIZE);
  localparam logic [ROB_WIDTH:0]  ONE_C  = (ROB_WIDTH+1)'(1);

  logic [SIZE-1:0]                busy_q, ready_q, misp_q;
  logic [SIZE-1:0][REG_WIDTH-1:0] reg_q;
  logic [SIZE-1:0][31:0]          data_q;
  logic [ROB_WIDTH-1:0]           head_q, tail_q, commit_rob_q;
  logic [ROB_WIDTH:0]             count_q, count_d;
  logic [REG_WIDTH-1:0]           commit_reg_q;
  logic [31:0]                    commit_data_q;
  logic                           flush_q;
  logic                           do_alloc, do_wb, do_commit;

  // A same-cycle commit gives no credit: a full buffer stays full this cycle.
  assign bus.alloc_ready   = (count_q < SIZE_C) && !flush_q;
  assign bus.alloc_rob_id  = tail_q;
  assign bus.commit_reg_id = commit_reg_q;
  assign bus.commit_data   = commit_data_q;
  assign bus.commit_rob_id = commit_rob_q;
  assign bus.flush         = flush_q;

  assign do_alloc  = bus.alloc_valid && bus.alloc_ready;
  assign do_wb     = bus.wb_valid && busy_q[bus.wb_rob_id];
  assign do_commit = busy_q[head_q] && ready_q[head_q];

  always_comb begin
    count_d = count_q;
    case ({do_alloc, do_commit})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Operand lookup, with a bypass of the writeback arriving this cycle.
  function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] id,
                                         input logic [SIZE-1:0]      busy,
                                         input logic [SIZE-1:0]      rdy,
                                         input logic [SIZE-1:0][31:0] data,
                                         input logic                 wv,
                                         input logic [ROB_WIDTH-1:0] wid,
                                         input logic [31:0]          wdata);
    logic [32:0] r;
    r = '0;
    if (busy[id]) begin
      if (wv && wid == id) r = {1'b1, wdata};
      else                 r = {rdy[id], data[id]};
    end
    return r;
  endfunction

  always_comb begin
    {bus.rob_ready_j, bus.rob_data_j} = lookup(bus.rob_rob_id_j, busy_q, ready_q, data_q,
                                               bus.wb_valid, bus.wb_rob_id, bus.wb_data);
    {bus.rob_ready_k, bus.rob_data_k} = lookup(bus.rob_rob_id_k, busy_q, ready_q, data_q,
                                               bus.wb_valid, bus.wb_rob_id, bus.wb_data);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q        <= '0;
      ready_q       <= '0;
      misp_q        <= '0;
      reg_q         <= '0;
      data_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_reg_q  <= '0;
      commit_data_q <= '0;
      commit_rob_q  <= '0;
      flush_q       <= 1'b0;
    end else if (rdy_in) begin
      if (flush_q) begin
        // Everything younger than the mispredicted branch is discarded here.
        busy_q       <= '0;
        ready_q      <= '0;
        misp_q       <= '0;
        head_q       <= '0;
        tail_q       <= '0;
        count_q      <= '0;
        commit_reg_q <= '0;
        flush_q      <= 1'b0;
      end else begin
        if (do_wb) begin
          ready_q[bus.wb_rob_id] <= 1'b1;
          data_q[bus.wb_rob_id]  <= bus.wb_data;
          misp_q[bus.wb_rob_id]  <= bus.wb_mispredict;
        end
        if (do_commit) begin
          busy_q[head_q] <= 1'b0;
          commit_reg_q   <= reg_q[head_q];
          commit_data_q  <= data_q[head_q];
          commit_rob_q   <= head_q;
          flush_q        <= misp_q[head_q];
          head_q         <= head_q + 1'b1;
        end else begin
          commit_reg_q <= '0;
        end
        if (do_alloc) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          misp_q[tail_q]  <= 1'b0;
          reg_q[tail_q]   <= bus.alloc_reg_id;
          tail_q          <= tail_q + 1'b1;
        end
        count_q <= count_d;
      end
    end
  end
endmodule

// File: tb/tb_commit_scheduler.sv
// Scoreboard bench for commit_scheduler: expected commits are queued as writebacks
// are driven and matched by a monitor whenever a fresh commit appears.
module tb_commit_scheduler;
  localparam int RW = 3;
  localparam int GW = 5;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic rdy_in;
  always #5 clk_in = ~clk_in;

  commit_scheduler_if #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) bus ();
  commit_scheduler #(.ROB_WIDTH(RW), .REG_WIDTH(GW)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .bus(bus)
  );

  typedef struct packed {
    logic [GW-1:0] rg;
    logic [31:0]   data;
    logic [RW-1:0] id;
    logic          fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic rdy_at_edge = 1'b0;

  // Outputs only change on edges where rdy_in was high, so that marks a fresh commit.
  always @(posedge clk_in) rdy_at_edge = rdy_in;

  always @(negedge clk_in) begin
    exp_t e, got;
    if (rst_n_in && rdy_at_edge && bus.commit_reg_id != '0) begin
      got = {bus.commit_reg_id, bus.commit_data, bus.commit_rob_id, bus.flush};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got reg %0d data %h id %0d flush %0b, none expected",
                 got.rg, got.data, got.id, got.fl);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL commit: got reg %0d data %h id %0d flush %0b, required reg %0d data %h id %0d flush %0b",
                   got.rg, got.data, got.id, got.fl, e.rg, e.data, e.id, e.fl);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n_in          = 1'b0;
    rdy_in            = 1'b1;
    bus.alloc_valid   = 1'b0;
    bus.alloc_reg_id  = '0;
    bus.wb_valid      = 1'b0;
    bus.wb_rob_id     = '0;
    bus.wb_data       = '0;
    bus.wb_mispredict = 1'b0;
    bus.rob_rob_id_j  = '0;
    bus.rob_rob_id_k  = '0;
    sb.delete();
    repeat (2) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    tick();
  endtask

  task automatic alloc(input logic [GW-1:0] rg, input logic [RW-1:0] exp_id);
    bus.alloc_valid  = 1'b1;
    bus.alloc_reg_id = rg;
    #0;
    checks++;
    if (bus.alloc_rob_id !== exp_id || bus.alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL alloc: got id %0d ready %0b, required id %0d ready 1",
               bus.alloc_rob_id, bus.alloc_ready, exp_id);
    end
    tick();
    bus.alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [RW-1:0] id, input logic [31:0] d, input logic m);
    bus.wb_valid      = 1'b1;
    bus.wb_rob_id     = id;
    bus.wb_data       = d;
    bus.wb_mispredict = m;
    tick();
    bus.wb_valid      = 1'b0;
    bus.wb_mispredict = 1'b0;
  endtask

  task automatic push(input logic [GW-1:0] rg, input logic [31:0] d,
                      input logic [RW-1:0] id, input logic fl);
    exp_t e;
    e = '{rg: rg, data: d, id: id, fl: fl};
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d commits pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    #2;
    checks++;
    if (bus.commit_reg_id !== '0 || bus.commit_data !== '0 || bus.commit_rob_id !== '0 ||
        bus.flush !== 1'b0 || bus.alloc_rob_id !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got reg %0d data %h id %0d flush %0b tail %0d, required all 0",
               bus.commit_reg_id, bus.commit_data, bus.commit_rob_id, bus.flush, bus.alloc_rob_id);
    end
    do_reset();
    checks++;
    if (bus.alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_alloc_ready: got %0b, required 1", bus.alloc_ready);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    alloc(5'd1, 3'd0);
    alloc(5'd2, 3'd1);
    alloc(5'd3, 3'd2);
    wb(3'd2, 32'hC, 1'b0);
    checks++;
    if (bus.commit_reg_id !== '0) begin
      errors++;
      $display("FAIL inorder_idle: got reg %0d, required 0", bus.commit_reg_id);
    end
    push(5'd1, 32'hA, 3'd0, 1'b0);
    wb(3'd0, 32'hA, 1'b0);
    push(5'd2, 32'hB, 3'd1, 1'b0);
    push(5'd3, 32'hC, 3'd2, 1'b0);
    wb(3'd1, 32'hB, 1'b0);
    drain("inorder");
    tick();
    checks++;
    if (bus.commit_reg_id !== '0) begin
      errors++;
      $display("FAIL inorder_after: got reg %0d, required 0", bus.commit_reg_id);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) alloc(GW'(i + 1), RW'(i));
    checks++;
    if (bus.alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got %0b, required 0", bus.alloc_ready);
    end
    bus.alloc_valid  = 1'b1;
    bus.alloc_reg_id = 5'd9;
    tick();
    bus.alloc_valid = 1'b0;
    checks++;
    if (bus.alloc_rob_id !== 3'd0) begin
      errors++;
      $display("FAIL full_ninth: got tail %0d, required 0", bus.alloc_rob_id);
    end
    push(5'd1, 32'h100, 3'd0, 1'b0);
    wb(3'd0, 32'h100, 1'b0);
    checks++;
    if (bus.alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_wb: got %0b, required 0", bus.alloc_ready);
    end
    tick();
    checks++;
    if (bus.alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_commit: got %0b, required 1", bus.alloc_ready);
    end
    alloc(5'd10, 3'd0);
    checks++;
    if (bus.alloc_rob_id !== 3'd1) begin
      errors++;
      $display("FAIL full_wrap: got tail %0d, required 1", bus.alloc_rob_id);
    end
    drain("full");
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(GW'(i + 1), RW'(i));
    wb(3'd2, 32'h22, 1'b0);
    wb(3'd3, 32'h33, 1'b0);
    wb(3'd1, 32'h11, 1'b1);
    push(5'd1, 32'h10, 3'd0, 1'b0);
    push(5'd2, 32'h11, 3'd1, 1'b1);
    wb(3'd0, 32'h10, 1'b0);
    drain("misp");
    checks++;
    if (bus.flush !== 1'b1 || bus.alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL misp_flush: got flush %0b ready %0b, required 1 0", bus.flush, bus.alloc_ready);
    end
    tick();
    checks++;
    if (bus.flush !== 1'b0 || bus.commit_reg_id !== '0 || bus.alloc_rob_id !== 3'd0 ||
        bus.alloc_ready !== 1'b1) begin
      errors++;
      $display("FAIL misp_clear: got flush %0b reg %0d tail %0d ready %0b, required 0 0 0 1",
               bus.flush, bus.commit_reg_id, bus.alloc_rob_id, bus.alloc_ready);
    end
    repeat (3) tick();
    alloc(5'd6, 3'd0);
  endtask

  task automatic test_lookup();
    do_reset();
    for (int i = 0; i < 5; i++) alloc(GW'(i + 1), RW'(i));
    bus.rob_rob_id_j = 3'd4;
    bus.rob_rob_id_k = 3'd5;
    bus.wb_valid     = 1'b1;
    bus.wb_rob_id    = 3'd4;
    bus.wb_data      = 32'h55;
    #1;
    checks++;
    if (bus.rob_ready_j !== 1'b1 || bus.rob_data_j !== 32'h55) begin
      errors++;
      $display("FAIL lookup_bypass: got %0b %h, required 1 00000055", bus.rob_ready_j, bus.rob_data_j);
    end
    checks++;
    if (bus.rob_ready_k !== 1'b0 || bus.rob_data_k !== 32'h0) begin
      errors++;
      $display("FAIL lookup_idle: got %0b %h, required 0 00000000", bus.rob_ready_k, bus.rob_data_k);
    end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    checks++;
    if (bus.rob_ready_j !== 1'b1 || bus.rob_data_j !== 32'h55) begin
      errors++;
      $display("FAIL lookup_stored: got %0b %h, required 1 00000055", bus.rob_ready_j, bus.rob_data_j);
    end
    bus.rob_rob_id_j = 3'd0;
    #1;
    checks++;
    if (bus.rob_ready_j !== 1'b0) begin
      errors++;
      $display("FAIL lookup_pending: got %0b, required 0", bus.rob_ready_j);
    end
  endtask

  task automatic test_rdy_hold();
    do_reset();
    alloc(5'd7, 3'd0);
    bus.wb_valid  = 1'b1;
    bus.wb_rob_id = 3'd0;
    bus.wb_data   = 32'h77;
    tick();
    bus.wb_valid     = 1'b0;
    rdy_in           = 1'b0;
    bus.alloc_valid  = 1'b1;
    bus.alloc_reg_id = 5'd8;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.commit_reg_id !== '0 || bus.alloc_rob_id !== 3'd1) begin
        errors++;
        $display("FAIL rdy_hold_%0d: got reg %0d tail %0d, required 0 1",
                 i, bus.commit_reg_id, bus.alloc_rob_id);
      end
    end
    bus.alloc_valid = 1'b0;
    push(5'd7, 32'h77, 3'd0, 1'b0);
    rdy_in = 1'b1;
    tick();
    checks++;
    if (bus.commit_reg_id !== 5'd7) begin
      errors++;
      $display("FAIL rdy_resume: got reg %0d, required 7", bus.commit_reg_id);
    end
    rdy_in = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.commit_reg_id !== 5'd7 || bus.commit_data !== 32'h77) begin
      errors++;
      $display("FAIL rdy_out_hold: got reg %0d data %h, required 7 00000077",
               bus.commit_reg_id, bus.commit_data);
    end
    rdy_in = 1'b1;
    drain("rdy");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 7; i++) alloc(GW'(i + 1), RW'(i));
    push(5'd1, 32'h9, 3'd0, 1'b0);
    wb(3'd0, 32'h9, 1'b0);
    push(5'd2, 32'h1234, 3'd1, 1'b0);
    wb(3'd1, 32'h1234, 1'b0);
    drain("midrst");
    #2 rst_n_in = 1'b0;
    #1;
    checks++;
    if (bus.commit_reg_id !== '0 || bus.commit_data !== '0 || bus.commit_rob_id !== '0 ||
        bus.alloc_rob_id !== '0) begin
      errors++;
      $display("FAIL midrst_async: got reg %0d data %h id %0d tail %0d, required all 0",
               bus.commit_reg_id, bus.commit_data, bus.commit_rob_id, bus.alloc_rob_id);
    end
    @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    tick();
    wb(3'd2, 32'hDEAD, 1'b0);
    repeat (2) tick();
    checks++;
    if (bus.alloc_rob_id !== 3'd0 || bus.commit_reg_id !== '0) begin
      errors++;
      $display("FAIL midrst_after: got tail %0d reg %0d, required 0 0",
               bus.alloc_rob_id, bus.commit_reg_id);
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_mispredict();
    test_lookup();
    test_rdy_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_scheduler.md
Name: commit_scheduler

Overview:
- In-order commit sequencer that owns the register file's commit port and flush line.
- Allocates ROB ids to decoded instructions and records writebacks.
- Retires at most one ready head entry per cycle, driving commit_reg_id/commit_data/commit_rob_id.
- Pulses flush after a mispredicted branch retires. Also answers the register file's j/k operand lookups by ROB id.

Parameters:
- ROB_WIDTH, 3, log2 of entry count (SIZE = 2^ROB_WIDTH = 8).
- REG_WIDTH, 5, architectural register index width (x0 = no write).

Ports:
- clk_in  in  1  clock
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; when 0, all state and outputs hold
- alloc_valid  in  1  decoder requests an entry
- alloc_reg_id  in  REG_WIDTH  destination register (0 = none)
- alloc_ready  out  1  entry available (count < SIZE && !flush)
- alloc_rob_id  out  ROB_WIDTH  id granted this cycle (= tail)
- wb_valid  in  1  result writeback strobe
- wb_rob_id  in  ROB_WIDTH  entry being written back
- wb_data  in  32  result value
- wb_mispredict  in  1  entry is a mispredicted branch
- commit_reg_id  out  REG_WIDTH  register to write; 0 when no commit
- commit_data  out  32  committed value
- commit_rob_id  out  ROB_WIDTH  id of committed entry
- flush  out  1  one-cycle pipeline flush pulse
- rob_rob_id_j / rob_rob_id_k  in  ROB_WIDTH  operand lookup ids
- rob_ready_j / rob_ready_k  out  1  looked-up entry has its value
- rob_data_j / rob_data_k  out  32  looked-up value

Behaviour:
- Per-entry state: busy, ready, mispredict, reg_id, data. Pointers: head, tail (ROB_WIDTH, wrap mod SIZE). count is ROB_WIDTH+1 bits.
- Reset (async, rst_n_in = 0): all entries non-busy; head = tail = count = 0; commit_reg_id = 0; commit_data = 0; commit_rob_id = 0; flush = 0.
- Nothing below occurs unless rdy_in = 1.
- Allocate when alloc_valid && alloc_ready:
  - entry[tail] busy = 1, ready = 0, mispredict = 0, reg_id = alloc_reg_id.
  - tail++, count++.
  - alloc_ready is combinational and gets no credit from a same-cycle commit, so full stays full for that cycle.
- Writeback when wb_valid and entry[wb_rob_id].busy:
  - set ready = 1, data = wb_data, mispredict = wb_mispredict.
  - A writeback to a non-busy entry is ignored.
- Commit: if entry[head].busy && ready:
  - next cycle commit_reg_id = reg_id, commit_data = data, commit_rob_id = head.
  - clear busy; head++, count--.
  - Otherwise commit_reg_id <= 0 (data and rob_id hold).
  - Latency is 1 cycle from a ready head to the commit outputs.
  - A writeback to the head makes it committable the following cycle (no same-cycle commit).
- Allocate and commit in the same cycle: count unchanged; both pointers advance.
- Mispredict: if the committed entry has mispredict = 1:
  - flush <= 1 for exactly one cycle, in the same cycle as its commit outputs.
  - That commit still writes its register (e.g. jal rd).
  - Entries younger than the branch are not committed.
- Cycle with flush = 1 (and rdy_in):
  - all entries cleared; head = tail = count = 0.
  - alloc and wb ignored; commit_reg_id <= 0; flush <= 0.
- Lookup is combinational, per port:
  - If wb_valid && wb_rob_id == id && entry busy: ready = 1, data = wb_data (bypass).
  - Else ready = busy && ready, data = entry data.
  - Non-busy id: ready = 0, data = 0.
- rdy_in = 0: pointers, entries and all registered outputs hold. A held flush stays high until the next rdy_in cycle, which performs the clear.
- Reset mid-operation: immediate clear regardless of rdy_in. Outstanding entries are lost; no commit is emitted.

Test Plan:
- Reset, then 3 allocs (reg 1, 2, 3) -> alloc_rob_id 0, 1, 2; writebacks 0xA, 0xB, 0xC in order 2, 0, 1 -> commits in order (reg1 0xA id0), (reg2 0xB id1), (reg3 0xC id2) on consecutive cycles. commit_reg_id = 0 before the first writeback and after the last commit.
- 8 allocs with no writeback -> alloc_ready = 0 and a 9th alloc is ignored. Write back id0 -> commit next cycle, alloc_ready = 1 one cycle later. A new alloc gets id0, and tail wraps to 1.
- Allocs ids 0–3, id1 written back with wb_mispredict = 1 and id2/id3 also ready -> commit id0 then id1 with flush = 1 on the same cycle as id1. id2 and id3 never commit; the next alloc gets id0.
- Lookup of id 4 with wb_valid on id 4 (data 0x55) in the same cycle -> rob_ready_j = 1, rob_data_j = 0x55. Lookup of a non-busy id -> ready 0.
- rdy_in low for 3 cycles with a ready head -> no pointer movement and outputs held; the commit appears on the first cycle after rdy_in rises.
- Assert rst_n_in low mid-stream with 5 busy entries -> outputs 0 immediately (asynchronously). After release, alloc_rob_id = 0 and commit_reg_id = 0.
